// File: rtl/cache_perf_pkg.sv
// Shared types and event indices for the cache performance counter block.
package cache_perf_pkg;

   typedef enum logic [1:0] {
      START    = 2'd0,
      STOP     = 2'd1,
      CLEAR    = 2'd2,
      SNAPSHOT = 2'd3
   } perf_cmd_e;

   typedef enum logic [1:0] {
      STOPPED    = 2'd0,
      RUNNING    = 2'd1,
      SNAP_DRAIN = 2'd2
   } perf_state_e;

   localparam int EV_HIT       = 0;
   localparam int EV_MISS      = 1;
   localparam int EV_READ      = 2;
   localparam int EV_WRITE     = 3;
   localparam int EV_WRITEBACK = 4;
   localparam int NUM_EVENTS   = 5;

endpackage

// File: rtl/perf_event_counter.sv
// Single event counter with clear and sticky overflow flag.
// CACHE_PERF_SATURATE_EN defined: saturate at all-ones; undefined: wrap to zero.
module perf_event_counter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            inc,
   input  logic            clr,
   output logic [XLEN-1:0] count,
   output logic            ovf
);

   logic [XLEN-1:0] count_q;
   logic            ovf_q;
   logic            at_max;

   assign at_max = &count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (clr) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (inc) begin
         if (at_max) begin
            ovf_q <= 1'b1;
`ifdef CACHE_PERF_SATURATE_EN
            count_q <= count_q;
`else
            count_q <= '0;
`endif
         end else begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/cache_perf_ctrl.sv
// Cache performance counter controller: command FSM, event pipeline and snapshot publish.
// Overflow behaviour of the counters selected by CACHE_PERF_SATURATE_EN.
module cache_perf_ctrl
   import cache_perf_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            evt_hit,
   input  logic            evt_miss,
   input  logic            evt_read,
   input  logic            evt_write,
   input  logic            evt_writeback,
   input  logic            cmd_valid,
   input  logic [1:0]      cmd_op,
   output logic            cmd_ready,
   output logic            running,
   output logic            snap_done,
   output logic [4:0]      ovf,
   output logic [XLEN-1:0] hit_value,
   output logic [XLEN-1:0] miss_value,
   output logic [XLEN-1:0] read_value,
   output logic [XLEN-1:0] write_value,
   output logic [XLEN-1:0] writeback_value
);

   perf_state_e state_q, state_d;
   perf_cmd_e   cmd;
   logic        resume_run_q, resume_run_d;
   logic        cmd_acc;
   logic        clr;
   logic        count_en;

   logic [NUM_EVENTS-1:0]           evt_p0;
   logic [NUM_EVENTS-1:0]           ev_p1;
   logic                            snap_vld_p1;
   logic                            snap_done_q;
   logic [NUM_EVENTS-1:0][XLEN-1:0] cnt;
   logic [NUM_EVENTS-1:0][XLEN-1:0] pub_q;
   logic [NUM_EVENTS-1:0]           cnt_ovf;

   assign cmd       = perf_cmd_e'(cmd_op);
   assign cmd_ready = (state_q != SNAP_DRAIN);
   assign running   = (state_q == RUNNING) || (state_q == SNAP_DRAIN);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign clr       = cmd_acc && (cmd == CLEAR);

   always_comb begin
      evt_p0               = '0;
      evt_p0[EV_HIT]       = evt_hit;
      evt_p0[EV_MISS]      = evt_miss;
      evt_p0[EV_READ]      = evt_read;
      evt_p0[EV_WRITE]     = evt_write;
      evt_p0[EV_WRITEBACK] = evt_writeback;
   end

   // A drain entered from STOPPED keeps counting disabled even though running is high.
   always_comb begin
      state_d      = state_q;
      resume_run_d = resume_run_q;
      count_en     = 1'b0;
      case (state_q)
         STOPPED: begin
            if (cmd_acc) begin
               case (cmd)
                  START:    state_d = RUNNING;
                  SNAPSHOT: begin
                     state_d      = SNAP_DRAIN;
                     resume_run_d = 1'b0;
                  end
                  default:  state_d = STOPPED;
               endcase
            end
         end
         RUNNING: begin
            count_en = 1'b1;
            if (cmd_acc) begin
               case (cmd)
                  STOP:     state_d = STOPPED;
                  SNAPSHOT: begin
                     state_d      = SNAP_DRAIN;
                     resume_run_d = 1'b1;
                  end
                  default:  state_d = RUNNING;
               endcase
            end
         end
         SNAP_DRAIN: begin
            count_en = resume_run_q;
            state_d  = resume_run_q ? RUNNING : STOPPED;
         end
         default: state_d = STOPPED;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= STOPPED;
         resume_run_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         resume_run_q <= resume_run_d;
      end
   end

   // Stage p1: sampled events and the drain-exit marker; publish happens one edge later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ev_p1       <= '0;
         snap_vld_p1 <= 1'b0;
      end else begin
         ev_p1       <= clr ? '0 : (evt_p0 & {NUM_EVENTS{count_en}});
         snap_vld_p1 <= (state_q == SNAP_DRAIN);
      end
   end

   // Stage p2: published values; a coincident CLEAR wins over the publish
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pub_q       <= '0;
         snap_done_q <= 1'b0;
      end else begin
         snap_done_q <= snap_vld_p1 && !clr;
         if (clr) begin
            pub_q <= '0;
         end else if (snap_vld_p1) begin
            pub_q <= cnt;
         end
      end
   end

   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ctr
      perf_event_counter #(
         .XLEN (XLEN)
      ) u_ctr (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (ev_p1[i]),
         .clr     (clr),
         .count   (cnt[i]),
         .ovf     (cnt_ovf[i])
      );
   end

   assign snap_done       = snap_done_q;
   assign ovf             = cnt_ovf;
   assign hit_value       = pub_q[EV_HIT];
   assign miss_value      = pub_q[EV_MISS];
   assign read_value      = pub_q[EV_READ];
   assign write_value     = pub_q[EV_WRITE];
   assign writeback_value = pub_q[EV_WRITEBACK];

endmodule

// File: tb/tb_cache_perf_ctrl.sv
// Self-checking bench for cache_perf_ctrl: directed scenarios then randomized traffic
// against a counting model (honours CACHE_PERF_SATURATE_EN).
module tb_cache_perf_ctrl;
   import cache_perf_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        evt_hit, evt_miss, evt_read, evt_write, evt_writeback;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        cmd_ready, running, snap_done;
   logic [4:0]  ovf;
   logic [31:0] hit_value, miss_value, read_value, write_value, writeback_value;

   int total = 0;
   int bad   = 0;

   localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

   // Model: true event totals, events in flight (visible one edge later), publish state
   longint unsigned m_cnt[5];
   bit [4:0]        m_pend;
   bit [4:0]        m_ovf;
   logic [31:0]     m_pub[5];
   bit              m_run, m_drain, m_snap_pend, m_snap_done;

   cache_perf_ctrl #(.XLEN(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .evt_hit         (evt_hit),
      .evt_miss        (evt_miss),
      .evt_read        (evt_read),
      .evt_write       (evt_write),
      .evt_writeback   (evt_writeback),
      .cmd_valid       (cmd_valid),
      .cmd_op          (cmd_op),
      .cmd_ready       (cmd_ready),
      .running         (running),
      .snap_done       (snap_done),
      .ovf             (ovf),
      .hit_value       (hit_value),
      .miss_value      (miss_value),
      .read_value      (read_value),
      .write_value     (write_value),
      .writeback_value (writeback_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_cnt[i] = 0;
         m_pub[i] = '0;
      end
      m_pend = '0; m_ovf = '0;
      m_run = 0; m_drain = 0; m_snap_pend = 0; m_snap_done = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ready"},   {31'd0, cmd_ready}, {31'd0, !m_drain});
      chk({tag, ".running"}, {31'd0, running},   {31'd0, (m_run || m_drain)});
      chk({tag, ".snapdone"},{31'd0, snap_done}, {31'd0, m_snap_done});
      chk({tag, ".ovf"},     {27'd0, ovf},       {27'd0, m_ovf});
      chk({tag, ".hit"},     hit_value,          m_pub[0]);
      chk({tag, ".miss"},    miss_value,         m_pub[1]);
      chk({tag, ".read"},    read_value,         m_pub[2]);
      chk({tag, ".write"},   write_value,        m_pub[3]);
      chk({tag, ".wb"},      writeback_value,    m_pub[4]);
   endtask

   task automatic drive(input bit cv, input logic [1:0] op, input bit [4:0] ev);
      cmd_valid     = cv;
      cmd_op        = op;
      evt_hit       = ev[0];
      evt_miss      = ev[1];
      evt_read      = ev[2];
      evt_write     = ev[3];
      evt_writeback = ev[4];
   endtask

   // Advance one clock: update the model from the inputs being sampled, then check.
   task automatic tick(input string tag);
      bit [4:0] ev;
      bit       acc, clr;
      ev  = {evt_writeback, evt_write, evt_read, evt_miss, evt_hit};
      acc = cmd_valid && !m_drain;
      clr = acc && (cmd_op == 2'd2);
      if (clr) begin
         for (int i = 0; i < 5; i++) begin
            m_cnt[i] = 0;
            m_pub[i] = '0;
         end
         m_pend = '0; m_ovf = '0; m_snap_done = 0;
      end else begin
         m_snap_done = m_snap_pend;
         if (m_snap_pend)
            for (int i = 0; i < 5; i++) m_pub[i] = m_cnt[i][31:0];
         for (int i = 0; i < 5; i++) begin
            if (m_pend[i]) begin
               if (m_cnt[i] == MAXV) begin
                  m_ovf[i] = 1'b1;
`ifdef CACHE_PERF_SATURATE_EN
                  m_cnt[i] = MAXV;
`else
                  m_cnt[i] = 0;
`endif
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
         end
         m_pend = ev & {5{m_run}};
      end
      m_snap_pend = m_drain;
      if (m_drain) m_drain = 0;
      else if (acc) begin
         case (cmd_op)
            2'd0:    m_run = 1;
            2'd1:    m_run = 0;
            2'd3:    m_drain = 1;
            default: ;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 2'd0, 5'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      reset_n = 1'b1;

      // Ten hits counted between START and STOP
      drive(1, START, 5'd0);              tick("t1.start");
      for (int i = 0; i < 10; i++) begin
         drive(0, START, 5'b00001);       tick("t1.hit");
      end
      drive(1, STOP, 5'd0);               tick("t1.stop");
      drive(1, SNAPSHOT, 5'd0);           tick("t1.snap");
      drive(0, START, 5'd0);              tick("t1.drain");
      chk("t1.no_early_done", {31'd0, snap_done}, 32'd0);
      tick("t1.pub");
      chk("t1.done", {31'd0, snap_done}, 32'd1);
      chk("t1.hit10", hit_value, 32'd10);
      chk("t1.miss0", miss_value, 32'd0);
      tick("t1.after");
      chk("t1.done_once", {31'd0, snap_done}, 32'd0);

      // Continuous reads across a snapshot
      drive(1, START, 5'b00100);          tick("t2.start");
      for (int i = 0; i < 5; i++) begin
         drive(0, START, 5'b00100);       tick("t2.rd");
      end
      drive(1, SNAPSHOT, 5'b00100);       tick("t2.snap");
      chk("t2.ready_drain", {31'd0, cmd_ready}, 32'd0);
      drive(0, START, 5'b00100);          tick("t2.drain");
      tick("t2.pub");
      chk("t2.read6", read_value, 32'd6);
      for (int i = 0; i < 3; i++) tick("t2.more");
      drive(1, SNAPSHOT, 5'b00100);       tick("t2.snap2");
      drive(0, START, 5'b00100);          tick("t2.drain2");
      tick("t2.pub2");
      chk("t2.read12", read_value, 32'd12);
      drive(1, STOP, 5'b00100);           tick("t2.stop");
      drive(0, START, 5'd0);              tick("t2.idle");

      // CLEAR collides with a miss event
      drive(1, CLEAR, 5'd0);              tick("t3.clr0");
      drive(1, START, 5'd0);              tick("t3.start");
      for (int i = 0; i < 7; i++) begin
         drive(0, START, 5'b00010);       tick("t3.miss");
      end
      drive(1, SNAPSHOT, 5'd0);           tick("t3.snap");
      drive(0, START, 5'd0);              tick("t3.drain");
      tick("t3.pub");
      chk("t3.miss7", miss_value, 32'd7);
      drive(1, CLEAR, 5'b00010);          tick("t3.clr");
      chk("t3.miss_clr", miss_value, 32'd0);
      chk("t3.read_clr", read_value, 32'd0);
      chk("t3.ovf_clr", {27'd0, ovf}, 32'd0);
      drive(0, START, 5'd0);              tick("t3.idle");
      drive(1, SNAPSHOT, 5'd0);           tick("t3.snap2");
      drive(0, START, 5'd0);              tick("t3.drain2");
      tick("t3.pub2");
      chk("t3.miss_lost", miss_value, 32'd0);
      drive(1, STOP, 5'd0);               tick("t3.stop");

      // Write counter at all-ones, then one more write
      drive(0, START, 5'd0);
      force dut.g_ctr[3].u_ctr.count_q = 32'hFFFF_FFFF;
      tick("t4.force");
      release dut.g_ctr[3].u_ctr.count_q;
      m_cnt[3] = MAXV;
      drive(1, START, 5'd0);              tick("t4.start");
      drive(0, START, 5'b01000);          tick("t4.wr");
      drive(0, START, 5'd0);              tick("t4.inc");
      chk("t4.ovf3", {27'd0, ovf}, 32'h0000_0008);
      drive(1, STOP, 5'd0);               tick("t4.stop");
      drive(1, SNAPSHOT, 5'd0);           tick("t4.snap");
      drive(0, START, 5'd0);              tick("t4.drain");
      tick("t4.pub");
`ifdef CACHE_PERF_SATURATE_EN
      chk("t4.write_sat", write_value, 32'hFFFF_FFFF);
`else
      chk("t4.write_wrap", write_value, 32'h0000_0000);
`endif
      drive(1, CLEAR, 5'd0);              tick("t4.clr");

      // Writebacks while stopped are ignored
      for (int i = 0; i < 3; i++) begin
         drive(0, START, 5'b10000);       tick("t6.stopped_wb");
      end
      drive(1, START, 5'b10000);          tick("t6.start");
      for (int i = 0; i < 3; i++) begin
         drive(0, START, 5'b10000);       tick("t6.wb");
         drive(0, START, 5'd0);           tick("t6.gap");
      end
      drive(1, SNAPSHOT, 5'd0);           tick("t6.snap");
      drive(0, START, 5'd0);              tick("t6.drain");
      tick("t6.pub");
      chk("t6.wb3", writeback_value, 32'd3);

      // Reset in the middle of a drain
      drive(1, SNAPSHOT, 5'b00001);       tick("t5.snap");
      drive(0, START, 5'd0);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("t5.rst");
      chk("t5.running0", {31'd0, running}, 32'd0);
      chk("t5.wb0", writeback_value, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("t5.post");
         chk("t5.no_done", {31'd0, snap_done}, 32'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 5'($urandom));
         tick("rnd");
      end
      drive(1, SNAPSHOT, 5'd0);           tick("end.snap");
      drive(0, START, 5'd0);              tick("end.drain");
      tick("end.pub");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
